fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage RISC-V pipeline; the consumer end of the hazard unit's StallF/StallD/FlushD controls and of the EX-stage redirect (PCSrcE/PCTargetE).
- Owns PCF. Issues requests to instruction memory over a variable-latency req/ack handshake. Drives the IF/ID register (InstrD, PCD, PCPlus4D, ValidD).
- Absorbs memory wait states by inserting NOP bubbles, and discards responses made stale by a redirect.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h00000000, PCF value after reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- StallF  in  1  hazard unit: do not start a new fetch.
- StallD  in  1  hazard unit: hold IF/ID contents.
- FlushD  in  1  hazard unit: clear IF/ID to bubble.
- PCSrcE  in  1  taken branch/jump resolved in EX.
- PCTargetE  in  XLEN  redirect target.
- imem_rdata  in  XLEN  instruction word, valid when imem_ack=1.
- imem_ack  in  1  one-cycle response strobe for the outstanding request.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  request address; word aligned.
- InstrD  out  XLEN  IF/ID instruction.
- PCD  out  XLEN  IF/ID PC.
- PCPlus4D  out  XLEN  IF/ID PC+4.
- ValidD  out  1  1 = real instruction, 0 = bubble.
- PCF  out  XLEN  current fetch PC (debug/trace).

Behaviour:
Reset (async, rst_n=0):
- PCF=RESET_PC, ReqAddr=RESET_PC.
- InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, imem_req=0.
- State=IDLE, skid buffer empty.
- Reset asserted mid-request abandons that request. The memory must ignore a late ack.

Handshake:
- imem_req and imem_addr stay stable from assertion until the cycle imem_ack=1 is sampled.
- At most one request is outstanding.
- An ack is honoured only while imem_req=1; otherwise it is ignored.
- imem_addr = ReqAddr, latched from PCF when the request starts.

States:
- IDLE: imem_req=0.
  - If PCSrcE: PCF<=PCTargetE.
  - If !StallF: ReqAddr<=(PCSrcE ? PCTargetE : PCF), go REQ.
- REQ: imem_req=1.
  - No ack, PCSrcE=1: PCF<=PCTargetE, go DRAIN.
  - Ack, PCSrcE=1: discard data, PCF<=PCTargetE, go IDLE.
  - Ack, PCSrcE=0, StallD=0: load IF/ID with {imem_rdata, ReqAddr, ReqAddr+4, ValidD=1}, PCF<=ReqAddr+4, go IDLE.
  - Ack, PCSrcE=0, StallD=1: store rdata in the skid buffer, PCF<=ReqAddr+4, go HOLD.
- DRAIN: imem_req=1 with the old ReqAddr.
  - Further PCSrcE updates PCF.
  - On ack: data discarded, go IDLE.
- HOLD: imem_req=0.
  - PCSrcE: buffer dropped, PCF<=PCTargetE, go IDLE.
  - Else if !StallD: IF/ID <= buffer entry {instr, ReqAddr, ReqAddr+4, 1}, go IDLE.

IF/ID update rule, applied every cycle in this priority order:
1. FlushD or PCSrcE: IF/ID = {NOP_INSTR, 0, 0, ValidD=0}.
2. StallD: hold.
3. A load as defined above.
4. Otherwise: bubble {NOP_INSTR, 0, 0, 0}.
- This means memory wait states appear downstream as bubbles, never as stalls.

Arithmetic and alignment:
- PC+4 is modulo 2^XLEN; 32'hFFFFFFFC + 4 = 0.
- PCTargetE[1:0] is forced to 0 when loaded.

Throughput:
- Zero-wait memory (ack in the request's first cycle) delivers one instruction per 2 cycles (REQ, IDLE).
- Back-to-back issue: when leaving REQ/HOLD into IDLE with StallF=0 and no redirect, go directly to REQ with ReqAddr = the new PCF. The IDLE cycle is skipped, giving one instruction per cycle.

Test Plan:
1. Reset release, ack in the same cycle as each req, no stalls -> imem_addr 0,4,8,C on consecutive cycles; ValidD=1 and PCD=0,4,8 one cycle after each ack.
2. Ack delayed 3 cycles for addr 0x10 -> imem_req/imem_addr held for 3 cycles; IF/ID shows 3 bubbles (ValidD=0, InstrD=0x00000013), then InstrD=rdata with PCD=0x10.
3. PCSrcE=1 with PCTargetE=0x200 while the request for 0x14 is pending -> FlushD bubble; DRAIN keeps addr 0x14 until ack; that data is never in IF/ID; next request is addr 0x200.
4. StallD=1 at ack for 0x20 (rdata=0xDEADBEEF), held 2 cycles -> IF/ID unchanged for 2 cycles, no new req; then InstrD=0xDEADBEEF, PCD=0x20, followed by a fetch of 0x24.
5. rst_n pulsed low mid-REQ -> outputs return to reset values immediately; a late ack is ignored; the first request after release is RESET_PC.
6. PCSrcE to PCTargetE=0xFFFFFFFC -> after delivery PCPlus4D=0 and the next fetch address is 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
// One request outstanding at a time; ack is a one-cycle strobe carrying rdata.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns PCF, fetches over a variable-latency req/ack bus and fills the IF/ID register.
// Wait states surface as bubbles; responses made stale by an EX redirect are drained and dropped.
module fetch_unit #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [XLEN-1:0]  NOP_INSTR = 'h13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  fetch_unit_if.master    imem,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [XLEN-1:0] PCF
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

  state_t          state;
  logic            reqQ;
  logic [XLEN-1:0] reqAddr;
  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] skidInstr;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] reqAddrPlus4;
  logic            ackSeen;
  logic            loadFromMem;
  logic            loadFromSkid;
  logic [XLEN-1:0] loadInstr;

  assign target       = PCTargetE & ~XLEN'(3);
  assign reqAddrPlus4 = reqAddr + XLEN'(4);
  // reqQ is high exactly in REQ/DRAIN, so acks arriving elsewhere are ignored
  assign ackSeen      = imem.imem_ack & reqQ;
  assign loadFromMem  = (state == REQ) & ackSeen & ~PCSrcE & ~StallD;
  assign loadFromSkid = (state == HOLD) & ~PCSrcE & ~StallD;
  assign loadInstr    = loadFromSkid ? skidInstr : imem.imem_rdata;

  assign imem.imem_req  = reqQ;
  assign imem.imem_addr = reqAddr;
  assign PCF            = pcF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      reqQ      <= 1'b0;
      reqAddr   <= RESET_PC;
      pcF       <= RESET_PC;
      skidInstr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (PCSrcE) pcF <= target;
          if (!StallF) begin
            reqAddr <= PCSrcE ? target : pcF;
            reqQ    <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (ackSeen) begin
            if (PCSrcE) begin
              pcF   <= target;
              reqQ  <= 1'b0;
              state <= IDLE;
            end else if (StallD) begin
              skidInstr <= imem.imem_rdata;
              pcF       <= reqAddrPlus4;
              reqQ      <= 1'b0;
              state     <= HOLD;
            end else begin
              pcF <= reqAddrPlus4;
              // back-to-back issue: skip the IDLE cycle and request the next word now
              if (!StallF) begin
                reqAddr <= reqAddrPlus4;
              end else begin
                reqQ  <= 1'b0;
                state <= IDLE;
              end
            end
          end else if (PCSrcE) begin
            pcF   <= target;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (PCSrcE) pcF <= target;
          if (ackSeen) begin
            reqQ  <= 1'b0;
            state <= IDLE;
          end
        end
        HOLD: begin
          if (PCSrcE) begin
            pcF   <= target;
            state <= IDLE;
          end else if (!StallD) begin
            if (!StallF) begin
              reqAddr <= pcF;
              reqQ    <= 1'b1;
              state   <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          reqQ  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD || PCSrcE) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (loadFromMem || loadFromSkid) begin
      InstrD   <= loadInstr;
      PCD      <= reqAddr;
      PCPlus4D <= reqAddrPlus4;
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle vectors for fetch_unit; each row gives inputs for one clock
// and the outputs expected just after that edge.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic        sf, sd, fd, ps;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        eReq;
    logic [31:0] eAddr, eInstr, ePCD, eP4;
    logic        eValid;
    logic [31:0] ePCF;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] InstrD, PCD, PCPlus4D, PCF;
  logic        ValidD;

  int nTests = 0;
  int nFail  = 0;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h00000000),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .StallF   (StallF),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .imem     (bus),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD),
    .PCF      (PCF)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic sf, logic sd, logic fd, logic ps, logic [31:0] tgt,
                              logic ack, logic [31:0] rdata, logic eReq, logic [31:0] eAddr,
                              logic [31:0] eInstr, logic [31:0] ePCD, logic [31:0] eP4,
                              logic eValid, logic [31:0] ePCF);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fd = fd; v.ps = ps; v.tgt = tgt; v.ack = ack; v.rdata = rdata;
    v.eReq = eReq; v.eAddr = eAddr; v.eInstr = eInstr; v.ePCD = ePCD; v.eP4 = eP4;
    v.eValid = eValid; v.ePCF = ePCF;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(string tag, logic eReq, logic [31:0] eAddr, logic [31:0] eInstr,
                          logic [31:0] ePCD, logic [31:0] eP4, logic eValid, logic [31:0] ePCF);
    chk({tag, ".req"},   32'(bus.imem_req), 32'(eReq));
    chk({tag, ".addr"},  bus.imem_addr,     eAddr);
    chk({tag, ".instr"}, InstrD,            eInstr);
    chk({tag, ".pcd"},   PCD,               ePCD);
    chk({tag, ".pc4"},   PCPlus4D,          eP4);
    chk({tag, ".valid"}, 32'(ValidD),       32'(eValid));
    chk({tag, ".pcf"},   PCF,               ePCF);
  endtask

  vec_t vq[$];

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;

    //            sf sd fd ps tgt           ack rdata          req addr          instr          pcd           p4            v  pcf
    // streaming with zero-wait memory
    vq.push_back(mk(0,0,0,0,32'h0,        0,32'h0,          1,32'h0,        NOP,           32'h0,        32'h0,        0,32'h0));
    vq.push_back(mk(0,0,0,0,32'h0,        1,32'h00100093,   1,32'h4,        32'h00100093,  32'h0,        32'h4,        1,32'h4));
    vq.push_back(mk(0,0,0,0,32'h0,        1,32'h00400113,   1,32'h8,        32'h00400113,  32'h4,        32'h8,        1,32'h8));
    vq.push_back(mk(0,0,0,0,32'h0,        1,32'h00800193,   1,32'hC,        32'h00800193,  32'h8,        32'hC,        1,32'hC));
    vq.push_back(mk(0,0,0,0,32'h0,        1,32'h00C00213,   1,32'h10,       32'h00C00213,  32'hC,        32'h10,       1,32'h10));
    // three wait states on 0x10
    vq.push_back(mk(0,0,0,0,32'h0,        0,32'h0,          1,32'h10,       NOP,           32'h0,        32'h0,        0,32'h10));
    vq.push_back(mk(0,0,0,0,32'h0,        0,32'h0,          1,32'h10,       NOP,           32'h0,        32'h0,        0,32'h10));
    vq.push_back(mk(0,0,0,0,32'h0,        0,32'h0,          1,32'h10,       NOP,           32'h0,        32'h0,        0,32'h10));
    vq.push_back(mk(0,0,0,0,32'h0,        1,32'h00A00113,   1,32'h14,       32'h00A00113,  32'h10,       32'h14,       1,32'h14));
    // redirect to 0x200 while 0x14 pending: drain then refetch
    vq.push_back(mk(0,0,1,1,32'h200,      0,32'h0,          1,32'h14,       NOP,           32'h0,        32'h0,        0,32'h200));
    vq.push_back(mk(0,0,0,0,32'h0,        0,32'h0,          1,32'h14,       NOP,           32'h0,        32'h0,        0,32'h200));
    vq.push_back(mk(0,0,0,0,32'h0,        1,32'hBAD0BAD0,   0,32'h14,       NOP,           32'h0,        32'h0,        0,32'h200));
    vq.push_back(mk(0,0,0,0,32'h0,        0,32'h0,          1,32'h200,      NOP,           32'h0,        32'h0,        0,32'h200));
    // redirect coincident with ack, misaligned target 0x21 -> 0x20
    vq.push_back(mk(0,0,1,1,32'h21,       1,32'h00000033,   0,32'h200,      NOP,           32'h0,        32'h0,        0,32'h20));
    vq.push_back(mk(0,0,0,0,32'h0,        0,32'h0,          1,32'h20,       NOP,           32'h0,        32'h0,        0,32'h20));
    // StallD at ack: skid buffer, held two cycles, then delivered and 0x24 fetched
    vq.push_back(mk(0,1,0,0,32'h0,        1,32'hDEADBEEF,   0,32'h20,       NOP,           32'h0,        32'h0,        0,32'h24));
    vq.push_back(mk(0,1,0,0,32'h0,        0,32'h0,          0,32'h20,       NOP,           32'h0,        32'h0,        0,32'h24));
    vq.push_back(mk(0,0,0,0,32'h0,        0,32'h0,          1,32'h24,       32'hDEADBEEF,  32'h20,       32'h24,       1,32'h24));
    vq.push_back(mk(0,0,0,0,32'h0,        0,32'h0,          1,32'h24,       NOP,           32'h0,        32'h0,        0,32'h24));
    // StallF stops issue; StallD holds a valid IF/ID
    vq.push_back(mk(1,0,0,0,32'h0,        1,32'h00200193,   0,32'h24,       32'h00200193,  32'h24,       32'h28,       1,32'h28));
    vq.push_back(mk(1,1,0,0,32'h0,        0,32'h0,          0,32'h24,       32'h00200193,  32'h24,       32'h28,       1,32'h28));
    vq.push_back(mk(1,0,0,0,32'h0,        0,32'h0,          0,32'h24,       NOP,           32'h0,        32'h0,        0,32'h28));
    // wrap-around at top of address space
    vq.push_back(mk(0,0,0,1,32'hFFFFFFFC, 0,32'h0,          1,32'hFFFFFFFC, NOP,           32'h0,        32'h0,        0,32'hFFFFFFFC));
    vq.push_back(mk(0,0,0,0,32'h0,        1,32'h0000006F,   1,32'h0,        32'h0000006F,  32'hFFFFFFFC, 32'h0,        1,32'h0));
    // FlushD overrides a load
    vq.push_back(mk(0,0,1,0,32'h0,        1,32'h00100093,   1,32'h4,        NOP,           32'h0,        32'h0,        0,32'h4));
    vq.push_back(mk(1,0,0,0,32'h0,        1,32'h00400113,   0,32'h4,        32'h00400113,  32'h4,        32'h8,        1,32'h8));
    // ack with no request outstanding is ignored
    vq.push_back(mk(1,0,0,0,32'h0,        1,32'hFFFFFFFF,   0,32'h4,        NOP,           32'h0,        32'h0,        0,32'h8));
    // redirect while in HOLD drops the buffered word
    vq.push_back(mk(0,0,0,0,32'h0,        0,32'h0,          1,32'h8,        NOP,           32'h0,        32'h0,        0,32'h8));
    vq.push_back(mk(0,1,0,0,32'h0,        1,32'hCAFEF00D,   0,32'h8,        NOP,           32'h0,        32'h0,        0,32'hC));
    vq.push_back(mk(0,1,0,1,32'h40,       0,32'h0,          0,32'h8,        NOP,           32'h0,        32'h0,        0,32'h40));
    vq.push_back(mk(0,0,0,0,32'h0,        0,32'h0,          1,32'h40,       NOP,           32'h0,        32'h0,        0,32'h40));

    #12;
    checkAll("reset", 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      StallF = vq[i].sf; StallD = vq[i].sd; FlushD = vq[i].fd; PCSrcE = vq[i].ps;
      PCTargetE = vq[i].tgt; bus.imem_ack = vq[i].ack; bus.imem_rdata = vq[i].rdata;
      @(posedge clk); #1;
      checkAll($sformatf("v%0d", i), vq[i].eReq, vq[i].eAddr, vq[i].eInstr, vq[i].ePCD,
               vq[i].eP4, vq[i].eValid, vq[i].ePCF);
    end

    // reset pulsed mid-request: immediate clear, late ack ignored, restart at RESET_PC
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    bus.imem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkAll("rstAsync", 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h12345678;
    @(posedge clk); #1;
    checkAll("rstHeld", 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkAll("rstLateAck", 1'b1, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00300213;
    @(posedge clk); #1;
    checkAll("rstFirst", 1'b1, 32'h4, 32'h00300213, 32'h0, 32'h4, 1'b1, 32'h4);
    bus.imem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
